cuadrados_16: RTL and testbench
===============================

# cuadrados_16

Sequential sum-of-squares stage that computes RR = A² + B² from two unsigned operands with a serial shift-add multiplier. It sits directly upstream of the 16-bit square-root block: its out_RR drives the root's radicand input, and its out_DONE pulse is that block's init. Together the two blocks form a vector-magnitude datapath. Control is a Moore ASM with the same init/done handshake used across the design.

## Interface
- N_BITS, default 8: operand width. The result width is 2·N_BITS, so the default result is 16 bits.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- init  input  1  start request; sampled only in IDLE.
- in_A  input  N_BITS  unsigned operand A.
- in_B  input  N_BITS  unsigned operand B.
- out_RR  output  2·N_BITS  A² + B² result; registered; held until the next accepted init.
- out_OVF  output  1  the true sum exceeded 2^(2·N_BITS)−1; registered with out_RR.
- out_BUSY  output  1  high in every state except IDLE.
- out_DONE  output  1  one-cycle pulse marking out_RR valid.

## Operation
- Datapath:
  - ACC is 2·N_BITS+1 bits wide.
  - MD is the 2·N_BITS-bit multiplicand register, loaded with the operand zero-extended.
  - MR is the N_BITS-bit multiplier register, loaded with the same operand.
  - CNT is a step counter of $clog2(N_BITS)+1 bits.
- Multiply step, once per cycle: if MR[0], then ACC ← ACC + MD; then MD ← MD<<1, MR ← MR>>1, CNT ← CNT−1.
- IDLE:
  - On init: ACC←0; MD, MR ← in_A; CNT←N_BITS.
  - Latch in_B into an internal register.
  - Go to SQ_A.
- SQ_A: perform one step per cycle. On the step where CNT reaches 1: reload MD/MR from the latched B, set CNT←N_BITS, go to SQ_B. ACC is not cleared.
- SQ_B: perform one step per cycle. On the last step, go to FIN.
- FIN:
  - out_OVF ← ACC[2·N_BITS].
  - out_RR ← ACC[2·N_BITS−1:0], unless saturation applies (see Configuration).
  - Go to DONE.
- DONE: out_DONE=1. Go to IDLE unconditionally.
- init is ignored outside IDLE. Operands are not re-sampled after acceptance, so in_A/in_B may change freely while busy.
- rst, in any state, including mid-multiply:
  - State → IDLE.
  - ACC, MD, MR, CNT, out_RR and out_OVF cleared to 0.
  - out_DONE=0, out_BUSY=0.
  - rst has priority over init in the same cycle.
- Zero operands are not short-circuited. Latency is fixed regardless of data.

## Timing
- Reset values: out_RR=0, out_OVF=0, out_BUSY=0, out_DONE=0, state=IDLE.
- Let t0 be the edge at which init is accepted in IDLE:
  - SQ_A steps occur on edges t0+1 … t0+N_BITS.
  - SQ_B steps occur on edges t0+N_BITS+1 … t0+2·N_BITS.
  - FIN writes the outputs on edge t0+2·N_BITS+1. That is t0+17 for the default N_BITS=8.
  - out_DONE is high for exactly the one cycle following t0+2·N_BITS+1.
  - The block is back in IDLE after edge t0+2·N_BITS+2.
- If init is held high continuously, the next acceptance is at t0+2·N_BITS+3, giving an initiation interval of 19 cycles at N_BITS=8.
- out_BUSY rises in the cycle after t0 and falls in the cycle after DONE.
- out_DONE is Moore-decoded from state and is glitch-free, so it can drive the root block's init directly.

## Configuration
- CUADRADOS_SAT_EN:
  - Defined: on overflow, out_RR is forced to all ones (0xFFFF at default width).
  - Undefined: out_RR is the wrapped value ACC[2·N_BITS−1:0].
  - In both cases out_OVF reports overflow identically.

## Structure
- Shared package holds:
  - The state encoding (IDLE, SQ_A, SQ_B, FIN, DONE; 3 bits).
  - The default N_BITS and the derived result-width constant. The root block reuses the result-width constant.
- One sub-module: mult_serie, containing the MD/MR/ACC shift-add step with load and step enables and CNT.
- The top level contains the FSM, the B latch and the output/saturation registers.

## Test plan
- A=3, B=4, one init pulse:
  - out_RR=25, out_OVF=0.
  - out_DONE high exactly one cycle, 17 edges after acceptance.
  - out_BUSY high in between.
- A=255, B=255 (true sum 130050):
  - out_OVF=1.
  - With CUADRADOS_SAT_EN: out_RR=0xFFFF.
  - Without: out_RR=0xFC02 (64514).
- A=181, B=181: out_RR=65522, out_OVF=0, which is the largest non-overflow case at equal operands.
- Accept init with A=10, B=0. During SQ_B, pulse init again and change in_A to 7. Required response: second init ignored, out_RR=100.
- rst asserted 5 cycles after init:
  - All outputs 0 on the next cycle and state returns to IDLE.
  - A following init with A=1, B=2 yields out_RR=5 with normal latency.
- init held high continuously with A=0, B=0: out_RR=0 and out_DONE pulses every 19 cycles.

Source files
------------

// File: rtl/cuadrados_16_pkg.sv
// cuadrados_16_pkg
// Shared definitions for the vector-magnitude datapath.
//   N_BITS_DEF : default operand width of the sum-of-squares stage
//   RES_W      : result width (2*N_BITS_DEF), also the radicand width of the root block
//   state_t    : control states of the sum-of-squares ASM (3-bit encoding)
package cuadrados_16_pkg;

    localparam int N_BITS_DEF = 8;
    localparam int RES_W      = 2 * N_BITS_DEF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SQ_A = 3'd1,
        ST_SQ_B = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cuadrados_16_mult.sv
// mult_serie
// Serial shift-add multiplier datapath with a step counter.
// Squaring is done by loading the same operand into MD and MR.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears ACC/MD/MR/CNT)
//   load      : load MD (zero-extended) and MR from operand, CNT <- N_BITS
//   clr_acc   : clear the accumulator
//   step      : one shift-add step: ACC += MD if MR[0]; MD<<=1; MR>>=1; CNT--
//   operand   : value loaded on load
//   acc       : 2*N_BITS+1 bit accumulator (top bit is the overflow bit)
//   cnt       : remaining steps of the current multiplication
module mult_serie
    import cuadrados_16_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    clr_acc,
    input  logic                    step,
    input  logic [N_BITS-1:0]       operand,
    output logic [2*N_BITS:0]       acc,
    output logic [$clog2(N_BITS):0] cnt
);

    localparam int CNT_W = $clog2(N_BITS) + 1;

    logic [2*N_BITS-1:0] md;
    logic [N_BITS-1:0]   mr;

    // A load may coincide with a step (switching from A to B): the step still
    // adds into ACC, while MD/MR/CNT take the freshly loaded values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            md  <= '0;
            mr  <= '0;
            cnt <= '0;
        end else begin
            if (clr_acc) begin
                acc <= '0;
            end else if (step && mr[0]) begin
                acc <= acc + {1'b0, md};
            end

            if (load) begin
                md  <= {{N_BITS{1'b0}}, operand};
                mr  <= operand;
                cnt <= CNT_W'(N_BITS);
            end else if (step) begin
                md  <= md << 1;
                mr  <= mr >> 1;
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cuadrados_16.sv
// cuadrados_16
// Sequential sum of squares RR = A^2 + B^2 using one serial multiplier,
// squaring A then B into the same accumulator.
// Optional feature: define CUADRADOS_SAT_EN to saturate out_RR to all ones
// on overflow (out_OVF reports overflow either way).
// Handshake: init is sampled only in IDLE; after acceptance out_BUSY stays
// high until IDLE is re-entered, and out_DONE pulses for one cycle when
// out_RR/out_OVF become valid. Results are held until the next accepted init.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   init       : start request
//   in_A, in_B : unsigned operands (captured at acceptance)
//   out_RR     : registered result
//   out_OVF    : registered overflow flag
//   out_BUSY   : high in every state except IDLE
//   out_DONE   : one-cycle result-valid pulse (Moore, glitch-free)
//   dbg_state  : current control state
module cuadrados_16
    import cuadrados_16_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init,
    input  logic [N_BITS-1:0]     in_A,
    input  logic [N_BITS-1:0]     in_B,
    output logic [2*N_BITS-1:0]   out_RR,
    output logic                  out_OVF,
    output logic                  out_BUSY,
    output logic                  out_DONE,
    output logic [2:0]            dbg_state
);

    localparam int CNT_W = $clog2(N_BITS) + 1;

    state_t              state;
    state_t              state_nx;
    logic                load;
    logic                clr_acc;
    logic                step;
    logic                last_step;
    logic [N_BITS-1:0]   b_reg;
    logic [N_BITS-1:0]   operand;
    logic [2*N_BITS:0]   acc;
    logic [CNT_W-1:0]    cnt;

    assign dbg_state = state;
    assign last_step = (cnt == CNT_W'(1));
    // A is loaded straight from the port at acceptance; B from its latch.
    assign operand   = (state == ST_IDLE) ? in_A : b_reg;

    mult_serie #(.N_BITS(N_BITS)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clr_acc (clr_acc),
        .step    (step),
        .operand (operand),
        .acc     (acc),
        .cnt     (cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (init)      state_nx = ST_SQ_A;
            ST_SQ_A: if (last_step) state_nx = ST_SQ_B;
            ST_SQ_B: if (last_step) state_nx = ST_FIN;
            ST_FIN:                 state_nx = ST_DONE;
            ST_DONE:                state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        load     = 1'b0;
        clr_acc  = 1'b0;
        step     = 1'b0;
        out_BUSY = (state != ST_IDLE);
        out_DONE = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                load    = init;
                clr_acc = init;
            end
            ST_SQ_A: begin
                step = 1'b1;
                load = last_step;   // switch MD/MR to B, keep ACC
            end
            ST_SQ_B: begin
                step = 1'b1;
            end
            default: ;
        endcase
    end

    // B is captured at acceptance so in_B may change while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_reg <= '0;
        end else if (state == ST_IDLE && init) begin
            b_reg <= in_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_RR  <= '0;
            out_OVF <= 1'b0;
        end else if (state == ST_FIN) begin
            out_OVF <= acc[2*N_BITS];
`ifdef CUADRADOS_SAT_EN
            out_RR  <= acc[2*N_BITS] ? '1 : acc[2*N_BITS-1:0];
`else
            out_RR  <= acc[2*N_BITS-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_cuadrados_16.sv
module tb_cuadrados_16;

  localparam int W = 16;

  logic          clk;
  logic          rst;
  logic          init;
  logic [7:0]    in_A;
  logic [7:0]    in_B;
  logic [W-1:0]  out_RR;
  logic          out_OVF;
  logic          out_BUSY;
  logic          out_DONE;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovf_q[$];

  cuadrados_16 dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .in_A      (in_A),
    .in_B      (in_B),
    .out_RR    (out_RR),
    .out_OVF   (out_OVF),
    .out_BUSY  (out_BUSY),
    .out_DONE  (out_DONE),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: plain arithmetic on the true sum
  function automatic int true_sum(input int a, input int b);
    return a * a + b * b;
  endfunction

  function automatic logic [W-1:0] model_rr(input int a, input int b);
    int s;
    s = true_sum(a, b);
    if (s > 65535) begin
`ifdef CUADRADOS_SAT_EN
      return 16'hFFFF;
`else
      return W'(s % 65536);
`endif
    end
    return W'(s);
  endfunction

  // One transaction from IDLE. glitch_k > 0 pulses init (with in_A=7) k cycles
  // after acceptance, which must be ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input int glitch_k);
    bit busy_ok;
    bit idle_ok;
    int done_k;
    int done_cnt;
    logic [W-1:0] e_rr;
    logic         e_ovf;
    exp_q.push_back(model_rr(a, b));
    exp_ovf_q.push_back(true_sum(a, b) > 65535);
    in_A = a;
    in_B = b;
    init = 1'b1;
    @(posedge clk); #1;           // acceptance edge t0
    init = 1'b0;
    in_A = 8'($urandom);
    in_B = 8'($urandom);
    busy_ok = 1'b1;
    idle_ok = 1'b1;
    done_k = -1;
    done_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;         // just after edge t0+k
      if (out_DONE) begin
        if (done_k < 0) done_k = k;
        done_cnt++;
      end
      if (k <= 17 && !out_BUSY) busy_ok = 1'b0;
      if (k >= 18 && out_BUSY) idle_ok = 1'b0;
      if (glitch_k > 0 && k == glitch_k) begin
        init = 1'b1;
        in_A = 8'd7;
      end else if (glitch_k > 0 && k == glitch_k + 1) begin
        init = 1'b0;
      end
    end
    e_rr  = exp_q.pop_front();
    e_ovf = exp_ovf_q.pop_front();
    check({tag, "_rr"}, 32'(out_RR), 32'(e_rr));
    check({tag, "_ovf"}, 32'(out_OVF), 32'(e_ovf));
    check({tag, "_done_lat"}, done_k, 17);
    check({tag, "_done_width"}, done_cnt, 1);
    check({tag, "_busy"}, 32'(busy_ok), 1);
    check({tag, "_idle_after"}, 32'(idle_ok), 1);
  endtask

  int dk[$];

  initial begin
    rst  = 1'b1;
    init = 1'b0;
    in_A = '0;
    in_B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rr", 32'(out_RR), 0);
    check("rst_ovf", 32'(out_OVF), 0);
    check("rst_busy", 32'(out_BUSY), 0);
    check("rst_done", 32'(out_DONE), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_op("a3b4", 8'd3, 8'd4, 0);
    run_op("a255b255", 8'd255, 8'd255, 0);
    run_op("a181b181", 8'd181, 8'd181, 0);
    run_op("glitch_sqb", 8'd10, 8'd0, 12);

    // random cases
    for (int i = 0; i < 8; i++) begin
      run_op("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    end

    // reset in the middle of a multiply
    in_A = 8'd200;
    in_B = 8'd100;
    init = 1'b1;
    @(posedge clk); #1;           // t0
    init = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rr", 32'(out_RR), 0);
    check("midrst_ovf", 32'(out_OVF), 0);
    check("midrst_busy", 32'(out_BUSY), 0);
    check("midrst_done", 32'(out_DONE), 0);
    check("midrst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", 8'd1, 8'd2, 0);

    // init held high: back-to-back operations
    in_A = 8'd0;
    in_B = 8'd0;
    init = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (out_DONE) begin
        dk.push_back(k);
        check("hold_rr", 32'(out_RR), 0);
      end
    end
    init = 1'b0;
    check("hold_enough_pulses", 32'(dk.size() >= 3), 1);
    if (dk.size() >= 3) begin
      check("hold_first", dk[0], 18);
      check("hold_ii_1", dk[1] - dk[0], 19);
      check("hold_ii_2", dk[2] - dk[1], 19);
    end
    repeat (25) @(posedge clk);
    #1;
    check("final_idle", 32'(out_BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
